// File: rtl/poker_hand_ctrl.sv
// rtl/poker_hand_ctrl.sv - video-poker hand controller: deal, discard/redraw, hand off to resolver
// Optional deck ack timeout with sticky deck_err is enabled by defining DECK_TIMEOUT_EN.
module poker_hand_ctrl #(
    parameter int HAND_SIZE      = 5,
    parameter int RANK_W         = 4,
    parameter int SUIT_W         = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        gui_deal,
    input  logic                        gui_draw,
    input  logic [HAND_SIZE-1:0]        discard,
    output logic                        deck_req,
    input  logic                        deck_ack,
    input  logic [RANK_W-1:0]           deck_rank,
    input  logic [SUIT_W-1:0]           deck_suit,
    output logic [HAND_SIZE*RANK_W-1:0] hand_rank,
    output logic [HAND_SIZE*SUIT_W-1:0] hand_suit,
    output logic [HAND_SIZE-1:0]        hand_valid,
    output logic                        busy,
    output logic                        resolve_req,
    input  logic                        resolve_ack,
    output logic                        deck_err
);

    localparam int IDX_W = (HAND_SIZE > 1) ? $clog2(HAND_SIZE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEAL_REQ,
        S_DEAL_GAP,
        S_HOLD,
        S_DRAW_SCAN,
        S_DRAW_REQ,
        S_DRAW_GAP,
        S_RESOLVE
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [HAND_SIZE-1:0]        dmask_q, dmask_d;
    logic [HAND_SIZE*RANK_W-1:0] hand_rank_q, hand_rank_d;
    logic [HAND_SIZE*SUIT_W-1:0] hand_suit_q, hand_suit_d;
    logic [HAND_SIZE-1:0]        hand_valid_q, hand_valid_d;
    logic                        deck_req_q, deck_req_d;
    logic                        resolve_req_q, resolve_req_d;

`ifdef DECK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]            tmo_cnt_q, tmo_cnt_d;
    logic                        deck_err_q, deck_err_d;
`endif

    function automatic logic [IDX_W-1:0] lowest_set(input logic [HAND_SIZE-1:0] m);
        lowest_set = '0;
        for (int i = HAND_SIZE - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        dmask_d       = dmask_q;
        hand_rank_d   = hand_rank_q;
        hand_suit_d   = hand_suit_q;
        hand_valid_d  = hand_valid_q;
        deck_req_d    = deck_req_q;
        resolve_req_d = resolve_req_q;
`ifdef DECK_TIMEOUT_EN
        deck_err_d    = deck_err_q;
        tmo_cnt_d     = (deck_req_q && !deck_ack) ? tmo_cnt_q + TMO_W'(1) : '0;
`endif

        case (state_q)
            S_IDLE: begin
                // The previous hand stays on display until a new deal is accepted.
                if (gui_deal) begin
                    hand_valid_d = '0;
                    idx_d        = '0;
                    deck_req_d   = 1'b1;
                    state_d      = S_DEAL_REQ;
`ifdef DECK_TIMEOUT_EN
                    deck_err_d   = 1'b0;
`endif
                end
            end
            S_DEAL_REQ, S_DRAW_REQ: begin
                if (deck_ack) begin
                    hand_rank_d[idx_q*RANK_W +: RANK_W] = deck_rank;
                    hand_suit_d[idx_q*SUIT_W +: SUIT_W] = deck_suit;
                    hand_valid_d[idx_q] = 1'b1;
                    deck_req_d          = 1'b0;
                    if (state_q == S_DRAW_REQ) begin
                        dmask_d[idx_q] = 1'b0;
                        state_d        = S_DRAW_GAP;
                    end else begin
                        state_d        = S_DEAL_GAP;
                    end
                end
            end
            S_DEAL_GAP: begin
                if (idx_q == IDX_W'(HAND_SIZE - 1)) begin
                    state_d    = S_HOLD;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    deck_req_d = 1'b1;
                    state_d    = S_DEAL_REQ;
                end
            end
            S_HOLD: begin
                if (gui_draw) begin
                    dmask_d = discard;
                    if (discard == '0) begin
                        resolve_req_d = 1'b1;
                        state_d       = S_RESOLVE;
                    end else begin
                        state_d       = S_DRAW_SCAN;
                    end
                end
            end
            S_DRAW_SCAN: begin
                if (dmask_q == '0) begin
                    resolve_req_d = 1'b1;
                    state_d       = S_RESOLVE;
                end else begin
                    idx_d      = lowest_set(dmask_q);
                    deck_req_d = 1'b1;
                    state_d    = S_DRAW_REQ;
                end
            end
            S_DRAW_GAP: begin
                state_d = S_DRAW_SCAN;
            end
            S_RESOLVE: begin
                if (resolve_ack) begin
                    resolve_req_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef DECK_TIMEOUT_EN
        // A deck that stops answering abandons the hand entirely.
        if (deck_req_q && !deck_ack && tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            deck_req_d   = 1'b0;
            deck_err_d   = 1'b1;
            hand_valid_d = '0;
            tmo_cnt_d    = '0;
            state_d      = S_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            dmask_q       <= '0;
            hand_rank_q   <= '0;
            hand_suit_q   <= '0;
            hand_valid_q  <= '0;
            deck_req_q    <= 1'b0;
            resolve_req_q <= 1'b0;
`ifdef DECK_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            deck_err_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            dmask_q       <= dmask_d;
            hand_rank_q   <= hand_rank_d;
            hand_suit_q   <= hand_suit_d;
            hand_valid_q  <= hand_valid_d;
            deck_req_q    <= deck_req_d;
            resolve_req_q <= resolve_req_d;
`ifdef DECK_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            deck_err_q    <= deck_err_d;
`endif
        end
    end

    assign deck_req    = deck_req_q;
    assign resolve_req = resolve_req_q;
    assign hand_rank   = hand_rank_q;
    assign hand_suit   = hand_suit_q;
    assign hand_valid  = hand_valid_q;
    assign busy        = !(state_q == S_IDLE || state_q == S_HOLD);
`ifdef DECK_TIMEOUT_EN
    assign deck_err    = deck_err_q;
`else
    assign deck_err    = 1'b0;
`endif

endmodule

// File: tb/tb_poker_hand_ctrl.sv
// tb/tb_poker_hand_ctrl.sv - randomized self-checking bench for poker_hand_ctrl
module tb_poker_hand_ctrl;

    localparam int HS  = 5;
    localparam int RW  = 4;
    localparam int SW  = 2;
    localparam int TMO = 8;

    logic                 clk;
    logic                 reset;
    logic                 gui_deal;
    logic                 gui_draw;
    logic [HS-1:0]        discard;
    logic                 deck_req;
    logic                 deck_ack;
    logic [RW-1:0]        deck_rank;
    logic [SW-1:0]        deck_suit;
    logic [HS*RW-1:0]     hand_rank;
    logic [HS*SW-1:0]     hand_suit;
    logic [HS-1:0]        hand_valid;
    logic                 busy;
    logic                 resolve_req;
    logic                 resolve_ack;
    logic                 deck_err;

    poker_hand_ctrl #(
        .HAND_SIZE      (HS),
        .RANK_W         (RW),
        .SUIT_W         (SW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .gui_deal    (gui_deal),
        .gui_draw    (gui_draw),
        .discard     (discard),
        .deck_req    (deck_req),
        .deck_ack    (deck_ack),
        .deck_rank   (deck_rank),
        .deck_suit   (deck_suit),
        .hand_rank   (hand_rank),
        .hand_suit   (hand_suit),
        .hand_valid  (hand_valid),
        .busy        (busy),
        .resolve_req (resolve_req),
        .resolve_ack (resolve_ack),
        .deck_err    (deck_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference hand and deck traffic, kept as plain arrays and queues.
    logic [RW-1:0]    exp_rank [HS];
    logic [SW-1:0]    exp_suit [HS];
    logic [RW+SW-1:0] card_q   [$];
    logic [RW+SW-1:0] given_q  [$];
    int               lat        = 1;
    bit               deck_mute  = 1'b0;
    int               req_cycles = 0;
    int               last_deal_cycles = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Deck: answers each request after 'lat' cycles of deck_req, one card per request.
    initial begin
        int cnt;
        logic [RW+SW-1:0] c;
        cnt       = 0;
        deck_ack  = 1'b0;
        deck_rank = '0;
        deck_suit = '0;
        forever begin
            @(negedge clk);
            if (deck_req) req_cycles++;
            if (deck_req && !deck_mute) begin
                cnt++;
                if (cnt > lat && !deck_ack) begin
                    if (card_q.size() > 0) c = card_q.pop_front();
                    else c = (RW+SW)'($urandom);
                    {deck_rank, deck_suit} = c;
                    deck_ack = 1'b1;
                    given_q.push_back(c);
                end else begin
                    deck_ack = 1'b0;
                end
            end else begin
                cnt      = 0;
                deck_ack = 1'b0;
            end
        end
    end

    task automatic check_hand(input string tag);
        for (int i = 0; i < HS; i++) begin
            check($sformatf("%s_rank%0d", tag, i), 64'(hand_rank[i*RW +: RW]), 64'(exp_rank[i]));
            check($sformatf("%s_suit%0d", tag, i), 64'(hand_suit[i*SW +: SW]), 64'(exp_suit[i]));
        end
    endtask

    task automatic do_deal(input bit with_draw);
        int n;
        given_q.delete();
        gui_deal = 1'b1;
        gui_draw = with_draw;
        tick();
        gui_deal = 1'b0;
        gui_draw = 1'b0;
        check("deal_busy", 64'(busy), 64'd1);
        check("deal_err_clear", 64'(deck_err), 64'd0);
        n = 1;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("deal_done", 64'(busy), 64'd0);
        last_deal_cycles = n - 1;
        check("deal_valid", 64'(hand_valid), 64'({HS{1'b1}}));
        check("deal_cards", 64'(given_q.size()), 64'(HS));
        for (int i = 0; i < HS; i++) begin
            if (given_q.size() > 0) {exp_rank[i], exp_suit[i]} = given_q.pop_front();
        end
        check_hand("deal");
    endtask

    task automatic do_draw(input logic [HS-1:0] mask);
        int n;
        int reqs0;
        given_q.delete();
        reqs0    = req_cycles;
        discard  = mask;
        gui_draw = 1'b1;
        tick();
        gui_draw = 1'b0;
        discard  = HS'($urandom);
        n = 1;
        while (!resolve_req && n < 200) begin
            tick();
            n++;
        end
        check("draw_resolve", 64'(resolve_req), 64'd1);
        if (mask == '0) begin
            check("skip_latency", 64'(n), 64'd1);
            check("skip_noreq", 64'(req_cycles - reqs0), 64'd0);
        end else begin
            check("draw_cards", 64'(given_q.size()), 64'($countones(mask)));
        end
        for (int i = 0; i < HS; i++) begin
            if (mask[i] && given_q.size() > 0) {exp_rank[i], exp_suit[i]} = given_q.pop_front();
        end
        check_hand("draw");
        check("draw_valid", 64'(hand_valid), 64'({HS{1'b1}}));
        repeat (3) tick();
        check("resolve_hold", 64'(resolve_req), 64'd1);
        resolve_ack = 1'b1;
        tick();
        resolve_ack = 1'b0;
        check("resolve_clr", 64'(resolve_req), 64'd0);
        check("resolve_idle", 64'(busy), 64'd0);
        tick();
        check_hand("idle_keep");
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        gui_deal    = 1'b0;
        gui_draw    = 1'b0;
        discard     = '0;
        resolve_ack = 1'b0;
        repeat (3) tick();
        check("rst_deck_req", 64'(deck_req), 64'd0);
        check("rst_resolve_req", 64'(resolve_req), 64'd0);
        check("rst_valid", 64'(hand_valid), 64'd0);
        check("rst_rank", 64'(hand_rank), 64'd0);
        check("rst_suit", 64'(hand_suit), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(deck_err), 64'd0);
        reset = 1'b0;
        tick();

        // Known deal: ranks 1..5 suit 0, ack on the second request cycle.
        lat = 1;
        for (int i = 1; i <= HS; i++) card_q.push_back({RW'(i), SW'(0)});
        do_deal(1'b0);
        check("deal_latency", 64'(last_deal_cycles), 64'd15);
        for (int i = 0; i < HS; i++) check($sformatf("known_rank%0d", i), 64'(hand_rank[i*RW +: RW]), 64'(i + 1));

        // Discard slots 1 and 4, deck supplies rank 9 then rank 10.
        card_q.push_back({RW'(9), SW'(0)});
        card_q.push_back({RW'(10), SW'(0)});
        do_draw(5'b10010);
        check("redraw_slot1", 64'(hand_rank[1*RW +: RW]), 64'd9);
        check("redraw_slot4", 64'(hand_rank[4*RW +: RW]), 64'd10);
        check("redraw_slot0", 64'(hand_rank[0*RW +: RW]), 64'd1);

        // Deal and draw together in IDLE: deal wins; gui_deal in HOLD is ignored.
        do_deal(1'b1);
        gui_deal = 1'b1;
        tick();
        gui_deal = 1'b0;
        check("hold_deal_busy", 64'(busy), 64'd0);
        check("hold_deal_req", 64'(deck_req), 64'd0);
        tick();
        check_hand("hold_ignore");

        // Empty discard goes straight to the resolver.
        do_draw('0);

        // Reset during the third card request.
        lat = 4;
        gui_deal = 1'b1;
        tick();
        gui_deal = 1'b0;
        n = 0;
        while (!(deck_req && hand_valid == 5'b00011) && n < 100) begin
            tick();
            n++;
        end
        check("rst_mid_reach", 64'(hand_valid), 64'd3);
        reset = 1'b1;
        tick();
        check("rst_mid_req", 64'(deck_req), 64'd0);
        check("rst_mid_valid", 64'(hand_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();
        check("rst_mid_stay_idle", 64'(busy), 64'd0);

        // Randomized rounds against the reference hand.
        for (int k = 0; k < 8; k++) begin
            lat = $urandom_range(1, 3);
            do_deal(k % 2 == 1);
            if (k == 3) do_draw('0);
            else do_draw(HS'($urandom));
        end

`ifdef DECK_TIMEOUT_EN
        deck_mute = 1'b1;
        gui_deal  = 1'b1;
        tick();
        gui_deal  = 1'b0;
        n = 0;
        while (deck_req && n < 100) begin
            n++;
            tick();
        end
        check("tmo_req_cycles", 64'(n), 64'(TMO));
        check("tmo_err", 64'(deck_err), 64'd1);
        check("tmo_idle", 64'(busy), 64'd0);
        check("tmo_valid", 64'(hand_valid), 64'd0);
        deck_mute = 1'b0;
        lat = 1;
        do_deal(1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
